// File: rtl/click_pkg.sv
// Shared defaults and sizing helpers for the synchronous click pipeline.
package click_pkg;

    localparam int CLICK_WIDTH = 16;
    localparam int CLICK_DEPTH = 4;
    localparam int CLICK_SYNC  = 2;

    // Bits needed to count 0..depth full stages.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/click_stage.sv
// One click stage: a phase bit, a data register and the fire condition.
module click_stage
    import click_pkg::*;
#(
    parameter int WIDTH = CLICK_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r,
    input  logic             a,
    input  logic [WIDTH-1:0] d_in,
    output logic             fire,
    output logic             p,
    output logic [WIDTH-1:0] d
);

    // A new token is waiting (r != p) and the previous one has been taken (a == p).
    assign fire = ~rst & (r != p) & (a == p);

    always_ff @(posedge clk) begin
        if (rst) begin
            p <= 1'b0;
            d <= '0;
        end else if (fire) begin
            p <= ~p;
            d <= d_in;
        end
    end

endmodule

// File: rtl/click_pipe_sync.sv
// Clocked 2-phase bundled-data click pipeline with input/output handshake synchronisers.
module click_pipe_sync
    import click_pkg::*;
#(
    parameter int WIDTH       = CLICK_WIDTH,
    parameter int DEPTH       = CLICK_DEPTH,
    parameter int SYNC_STAGES = CLICK_SYNC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_R,
    output logic                          in_A,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_R,
    input  logic                          out_A,
    output logic [WIDTH-1:0]              data_out,
    output logic [occ_width(DEPTH)-1:0]   occupancy,
    output logic [DEPTH-1:0]              fire
);

    // Handshake: 2-phase. Every toggle of a request is one token whose data is
    // stable until the matching acknowledge toggles; the ack toggle frees the slot.
    localparam int OCC_W = occ_width(DEPTH);

    logic in_r_s;
    logic out_a_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign in_r_s  = in_R;
            assign out_a_s = out_A;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] in_r_q;
            logic [SYNC_STAGES-1:0] out_a_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    in_r_q  <= '0;
                    out_a_q <= '0;
                end else begin
                    in_r_q[0]  <= in_R;
                    out_a_q[0] <= out_A;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        in_r_q[k]  <= in_r_q[k-1];
                        out_a_q[k] <= out_a_q[k-1];
                    end
                end
            end

            assign in_r_s  = in_r_q[SYNC_STAGES-1];
            assign out_a_s = out_a_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [DEPTH-1:0] p;
    logic [DEPTH-1:0] full;
    logic [WIDTH-1:0] d [DEPTH];

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic             r_i;
            logic             a_i;
            logic [WIDTH-1:0] d_in_i;

            if (i == 0) begin : g_first
                assign r_i    = in_r_s;
                assign d_in_i = in_data;
            end else begin : g_mid
                assign r_i    = p[i-1];
                assign d_in_i = d[i-1];
            end

            if (i == DEPTH - 1) begin : g_last
                assign a_i = out_a_s;
            end else begin : g_next
                assign a_i = p[i+1];
            end

            // A stage holds a token until its successor has matched its phase.
            assign full[i] = p[i] ^ a_i;

            click_stage #(.WIDTH(WIDTH)) u_stage (
                .clk  (clk),
                .rst  (rst),
                .r    (r_i),
                .a    (a_i),
                .d_in (d_in_i),
                .fire (fire[i]),
                .p    (p[i]),
                .d    (d[i])
            );
        end
    endgenerate

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(full[i]);
        end
    end

    assign in_A     = p[0];
    assign out_R    = p[DEPTH-1];
    assign data_out = d[DEPTH-1];

endmodule

// File: tb/tb_click_pipe_sync.sv
// Bench for click_pipe_sync: default build plus a WIDTH=1/DEPTH=1/SYNC=0 build.
module tb_click_pipe_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_r_v [2];
    logic        out_a_v[2];
    logic [15:0] din_v  [2];

    logic        in_a0, out_r0;
    logic [15:0] dout0;
    logic [2:0]  occ0;
    logic [3:0]  fire0;
    logic        in_a1, out_r1;
    logic [0:0]  dout1;
    logic [0:0]  occ1;
    logic [0:0]  fire1;

    int checks = 0;
    int errors = 0;

    localparam int DEP[2] = '{4, 1};
    localparam int SYN[2] = '{2, 0};

    always #5 clk = ~clk;

    click_pipe_sync #(.WIDTH(16), .DEPTH(4), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .in_R(in_r_v[0]), .in_A(in_a0), .in_data(din_v[0]),
        .out_R(out_r0), .out_A(out_a_v[0]), .data_out(dout0), .occupancy(occ0), .fire(fire0)
    );

    click_pipe_sync #(.WIDTH(1), .DEPTH(1), .SYNC_STAGES(0)) dut1 (
        .clk(clk), .rst(rst), .in_R(in_r_v[1]), .in_A(in_a1), .in_data(din_v[1][0:0]),
        .out_R(out_r1), .out_A(out_a_v[1]), .data_out(dout1), .occupancy(occ1), .fire(fire1)
    );

    function automatic logic [15:0] msk(input int u);
        return (u == 0) ? 16'hFFFF : 16'h0001;
    endfunction
    function automatic logic get_in_a(input int u);
        return (u == 0) ? in_a0 : in_a1;
    endfunction
    function automatic logic get_out_r(input int u);
        return (u == 0) ? out_r0 : out_r1;
    endfunction
    function automatic logic [15:0] get_dout(input int u);
        return (u == 0) ? dout0 : {15'b0, dout1};
    endfunction
    function automatic logic [3:0] get_fire(input int u);
        return (u == 0) ? fire0 : {3'b0, fire1};
    endfunction
    function automatic int get_occ(input int u);
        return (u == 0) ? int'(occ0) : int'(occ1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            in_r_v[u] = 1'b0; out_a_v[u] = 1'b0; din_v[u] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Single token through an empty pipe, checked edge by edge.
    task automatic lat_check(input int u, input logic [15:0] data);
        logic new_a, new_r, ea, er;
        logic [3:0] ef;
        int s, d;
        s = SYN[u];
        d = DEP[u];
        @(posedge clk); #1;
        new_r = ~get_out_r(u);
        din_v[u] = data;
        in_r_v[u] = ~in_r_v[u];
        new_a = in_r_v[u];
        for (int j = 0; j <= s + d + 1; j++) begin
            @(negedge clk);
            ef = (j >= s && j - s < d) ? 4'(1 << (j - s)) : 4'b0;
            ea = (j > s) ? new_a : ~new_a;
            er = (j > s + d - 1) ? new_r : ~new_r;
            chk("lat fire", get_fire(u), ef);
            chk("lat in_A", get_in_a(u), ea);
            chk("lat out_R", get_out_r(u), er);
            if (j > s + d - 1) chk("lat data", get_dout(u), data & msk(u));
        end
        chk("lat occupancy", get_occ(u), 1);
    endtask

    // Fill with DEPTH+1 tokens then drain, against a token-count model:
    // accepted = min(sent, consumed+DEPTH), delivered = min(accepted, consumed+1).
    task automatic fill_drain_model(input int u);
        int n, s, c, acc, del;
        logic [15:0] tok[$];
        logic ea, er;
        logic [15:0] ed;
        n = DEP[u] + 1;
        s = 0;
        c = 0;
        for (int k = 0; k < n; k++) tok.push_back(16'(k + 1) & msk(u));
        for (int step = 0; step < 2 * n; step++) begin
            @(posedge clk); #1;
            if (step < n) begin
                din_v[u] = tok[s]; in_r_v[u] = ~in_r_v[u]; s++;
            end else begin
                out_a_v[u] = ~out_a_v[u]; c++;
            end
            repeat (12) @(negedge clk);
            acc = (s < c + DEP[u]) ? s : c + DEP[u];
            del = (acc < c + 1) ? acc : c + 1;
            ea = acc[0];
            er = del[0];
            ed = (del > 0) ? tok[del-1] : 16'h0;
            chk("model in_A", get_in_a(u), ea);
            chk("model out_R", get_out_r(u), er);
            chk("model data", get_dout(u), ed);
            chk("model occupancy", get_occ(u), acc - c);
        end
    endtask

    // Source/sink traffic: eager (streaming) or randomly paced, scoreboarded in order.
    task automatic run_traffic(input int u, input int n, input bit rnd);
        logic [15:0] exp_q[$];
        logic [15:0] dv;
        logic last_or;
        int sent, recv, acks, cyc, last_t, budget;
        sent = 0; recv = 0; acks = 0; cyc = 0; last_t = 0;
        budget = n * 60 + 200;
        last_or = get_out_r(u);
        while ((recv < n || acks < n) && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (sent < n && in_r_v[u] == get_in_a(u) && (!rnd || $urandom_range(0, 2) == 0)) begin
                dv = 16'($urandom) & msk(u);
                din_v[u] = dv;
                in_r_v[u] = ~in_r_v[u];
                exp_q.push_back(dv);
                sent++;
            end
            if (out_a_v[u] != get_out_r(u) && (!rnd || $urandom_range(0, 2) == 0)) begin
                out_a_v[u] = ~out_a_v[u];
                acks++;
            end
            @(negedge clk);
            if (get_out_r(u) != last_or) begin
                last_or = get_out_r(u);
                if (exp_q.size() == 0) chk("unexpected token", 1, 0);
                else chk("traffic data", get_dout(u), exp_q.pop_front());
                if (!rnd && recv > 0) chk("stream gap ok", (cyc - last_t) <= 2 * SYN[u] + 2, 1);
                last_t = cyc;
                recv++;
            end
            if (rnd) chk("occupancy bound", get_occ(u) <= DEP[u], 1);
        end
        chk("traffic completed", (recv == n && acks == n), 1);
        repeat (10) @(negedge clk);
        chk("traffic final occupancy", get_occ(u), 0);
        chk("traffic final in_A", get_in_a(u), in_r_v[u]);
    endtask

    typedef struct {
        bit          send;
        logic [15:0] data;
        logic        exp_in_a;
        logic        exp_out_r;
        logic [15:0] exp_dout;
        int          exp_occ;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int tmo;
        // send: toggle in_R with data, otherwise toggle out_A; then settle 12 cycles.
        tbl[0] = '{1, 16'h0001, 1'b1, 1'b1, 16'h0001, 1};
        tbl[1] = '{1, 16'h0002, 1'b0, 1'b1, 16'h0001, 2};
        tbl[2] = '{1, 16'h0003, 1'b1, 1'b1, 16'h0001, 3};
        tbl[3] = '{1, 16'h0004, 1'b0, 1'b1, 16'h0001, 4};
        tbl[4] = '{1, 16'h0005, 1'b0, 1'b1, 16'h0001, 4};
        tbl[5] = '{0, 16'h0000, 1'b1, 1'b0, 16'h0002, 4};
        tbl[6] = '{0, 16'h0000, 1'b1, 1'b1, 16'h0003, 3};
        tbl[7] = '{0, 16'h0000, 1'b1, 1'b0, 16'h0004, 2};
        tbl[8] = '{0, 16'h0000, 1'b1, 1'b1, 16'h0005, 1};
        tbl[9] = '{0, 16'h0000, 1'b1, 1'b1, 16'h0005, 0};

        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            in_r_v[u] = 1'b0; out_a_v[u] = 1'b0; din_v[u] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset in_A", get_in_a(u), 0);
            chk("reset out_R", get_out_r(u), 0);
            chk("reset data", get_dout(u), 0);
            chk("reset occupancy", get_occ(u), 0);
            chk("reset fire", get_fire(u), 0);
        end
        @(posedge clk); #1 rst = 1'b0;

        lat_check(0, 16'hA5A5);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (tbl[i].send) begin
                din_v[0] = tbl[i].data; in_r_v[0] = ~in_r_v[0];
            end else begin
                out_a_v[0] = ~out_a_v[0];
            end
            repeat (12) @(negedge clk);
            chk("table in_A", in_a0, tbl[i].exp_in_a);
            chk("table out_R", out_r0, tbl[i].exp_out_r);
            chk("table data", dout0, tbl[i].exp_dout);
            chk("table occupancy", occ0, tbl[i].exp_occ);
        end

        do_reset();
        run_traffic(0, 20, 1'b0);

        // Two tokens in flight, then a one-edge reset.
        do_reset();
        @(posedge clk); #1;
        din_v[0] = 16'h1111; in_r_v[0] = 1'b1;
        tmo = 0;
        while (in_a0 != 1'b1 && tmo < 20) begin
            @(posedge clk); #1;
            tmo++;
        end
        chk("midflight first ack", in_a0, 1);
        din_v[0] = 16'h2222; in_r_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; in_r_v[0] = 1'b0; out_a_v[0] = 1'b0;
        @(negedge clk);
        chk("fire forced in reset", fire0, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midflight in_A", in_a0, 0);
        chk("midflight out_R", out_r0, 0);
        chk("midflight data", dout0, 0);
        chk("midflight occupancy", occ0, 0);
        lat_check(0, 16'h3C3C);

        do_reset();
        lat_check(1, 16'h0001);
        do_reset();
        fill_drain_model(1);
        do_reset();
        fill_drain_model(0);

        do_reset();
        run_traffic(0, 60, 1'b1);
        run_traffic(1, 60, 1'b1);
        run_traffic(1, 20, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
